// File: rtl/r_burst_id_restorer.sv
// Purpose : buffers one downstream read burst tagged with a unique ID, frees that UID
//           in the tag map, then replays the burst upstream with RID = restored original ID.
// Latency : last beat accepted at T -> free_req at T+1 -> free_ack at T+2 -> first m_rvalid at T+3.
// Backpressure: s_rready is high only while collecting. Upstream m_rready stalls hold all m_* outputs stable.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   s_r*  (valid/ready/id/...) downstream R channel; s_rid carries the unique ID
//   free_req / free_unique_id  one-cycle free strobe and the UID being freed
//   restored_id                original ID returned by the tag map, valid in the free_req cycle
//   free_ack                   tag-map acknowledge, expected one cycle after free_req
//   m_r*  (valid/ready/id/...) upstream R channel carrying the restored ID
//   busy                       high whenever the block is not collecting
//   err                        sticky protocol error flag, present only with R_BURST_ID_RESTORER_ERR_CHECK_EN
//
// Optional feature macro: R_BURST_ID_RESTORER_ERR_CHECK_EN (adds the err output).

module r_burst_id_restorer #(
    parameter int ID_WIDTH    = 4,
    parameter int UID_W       = 8,
    parameter int DATA_W      = 64,
    parameter int BURST_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [UID_W-1:0]    s_rid,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,
    output logic                free_req,
    output logic [UID_W-1:0]    free_unique_id,
    input  logic [ID_WIDTH-1:0] restored_id,
    input  logic                free_ack,
    output logic                m_rvalid,
    input  logic                m_rready,
    output logic [ID_WIDTH-1:0] m_rid,
    output logic [DATA_W-1:0]   m_rdata,
    output logic [1:0]          m_rresp,
    output logic                m_rlast,
    output logic                busy
`ifdef R_BURST_ID_RESTORER_ERR_CHECK_EN
    ,
    output logic                err
`endif
);

    localparam int CNT_W = $clog2(BURST_DEPTH + 1);
    localparam int PTR_W = (BURST_DEPTH > 1) ? $clog2(BURST_DEPTH) : 1;

    typedef enum logic [1:0] {S_COLLECT, S_FREE, S_ACK, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [UID_W-1:0]      uid_q, uid_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [DATA_W+1:0]     buf_q [BURST_DEPTH];
    logic [DATA_W+1:0]     rd_entry;

    logic beat_acc;
    logic is_full;
    logic last_idx;
    logic m_hs;
    logic buf_we;

    assign beat_acc = s_rvalid && s_rready;
    assign is_full  = (cnt_q == CNT_W'(BURST_DEPTH));
    assign last_idx = (CNT_W'(rd_ptr_q) == (cnt_q - CNT_W'(1)));
    assign m_hs     = m_rvalid && m_rready;
    assign rd_entry = buf_q[rd_ptr_q];
    // Once full, only the last beat is stored; it lands on the final entry because
    // wr_ptr saturates there, so the upstream burst still ends with the true RRESP.
    assign buf_we   = beat_acc && (!is_full || s_rlast);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_COLLECT;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: if (beat_acc && s_rlast) state_d = S_FREE;
            S_FREE:    state_d = S_ACK;
            S_ACK:     if (free_ack) state_d = S_DRAIN;
            S_DRAIN:   if (m_hs && m_rlast) state_d = S_COLLECT;
            default:   state_d = S_COLLECT;
        endcase
    end

    // Output logic
    always_comb begin
        s_rready       = 1'b0;
        free_req       = 1'b0;
        free_unique_id = '0;
        m_rvalid       = 1'b0;
        m_rid          = '0;
        m_rdata        = '0;
        m_rresp        = 2'b00;
        m_rlast        = 1'b0;
        busy           = (state_q != S_COLLECT);
        case (state_q)
            S_COLLECT: s_rready = 1'b1;
            S_FREE: begin
                free_req       = 1'b1;
                free_unique_id = uid_q;
            end
            S_DRAIN: begin
                m_rvalid = 1'b1;
                m_rid    = id_q;
                m_rdata  = rd_entry[DATA_W+1:2];
                m_rresp  = rd_entry[1:0];
                m_rlast  = last_idx;
            end
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        uid_d    = uid_q;
        id_d     = id_q;
        if (beat_acc) begin
            if (cnt_q == '0) uid_d = s_rid;
            if (!is_full) cnt_d = cnt_q + CNT_W'(1);
            if (wr_ptr_q != PTR_W'(BURST_DEPTH - 1)) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (state_q == S_FREE) id_d = restored_id;
        if (m_hs) begin
            if (m_rlast) begin
                cnt_d    = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end else begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            uid_q    <= '0;
            id_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            uid_q    <= uid_d;
            id_q     <= id_d;
        end
    end

    // Beat storage needs no reset: count and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[wr_ptr_q] <= {s_rdata, s_rresp};
    end

`ifdef R_BURST_ID_RESTORER_ERR_CHECK_EN
    logic err_q, err_d;
    logic ack_first_q;

    always_comb begin
        err_d = err_q;
        if (beat_acc && is_full) err_d = 1'b1;
        if (beat_acc && (cnt_q != '0) && (s_rid != uid_q)) err_d = 1'b1;
        if (free_ack && (state_q != S_ACK)) err_d = 1'b1;
        if ((state_q == S_ACK) && ack_first_q && !free_ack) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q       <= 1'b0;
            ack_first_q <= 1'b0;
        end else begin
            err_q       <= err_d;
            ack_first_q <= (state_q == S_FREE);
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_r_burst_id_restorer.sv
module tb_r_burst_id_restorer;

    localparam int IDW   = 4;
    localparam int UW    = 8;
    localparam int DW    = 64;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           s_rvalid;
    logic           s_rready;
    logic [UW-1:0]  s_rid;
    logic [DW-1:0]  s_rdata;
    logic [1:0]     s_rresp;
    logic           s_rlast;
    logic           free_req;
    logic [UW-1:0]  free_unique_id;
    logic [IDW-1:0] restored_id;
    logic           free_ack;
    logic           m_rvalid;
    logic           m_rready;
    logic [IDW-1:0] m_rid;
    logic [DW-1:0]  m_rdata;
    logic [1:0]     m_rresp;
    logic           m_rlast;
    logic           busy;
`ifdef R_BURST_ID_RESTORER_ERR_CHECK_EN
    logic           err;
`endif

    r_burst_id_restorer #(
        .ID_WIDTH(IDW), .UID_W(UW), .DATA_W(DW), .BURST_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .free_req(free_req), .free_unique_id(free_unique_id),
        .restored_id(restored_id), .free_ack(free_ack),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .busy(busy)
`ifdef R_BURST_ID_RESTORER_ERR_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int free_cnt = 0;
    int rdy_mode = 0;   // 0: always ready, 1: pattern 1,0,0,1 then ready, 2: random

    logic [DW-1:0] bd [$];
    logic [1:0]    br [$];

    always @(negedge clk) if (!rst && free_req) free_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drives the burst in bd/br, services the free handshake and drains upstream.
    // Entry and exit are both at a falling edge; on exit the block must be ready again.
    task automatic run_burst(input logic [UW-1:0] uid, input logic [IDW-1:0] rid);
        int n;
        int cyc;
        bit done;
        bit stalled;
        logic [DW-1:0]  exp_d [$];
        logic [1:0]     exp_r [$];
        logic [DW-1:0]  got_d [$];
        logic [1:0]     got_r [$];
        logic           got_l [$];
        logic [IDW-1:0] got_id [$];
        logic [DW-1:0]  pd;
        logic [1:0]     pr;
        logic [IDW-1:0] pid;
        logic           pl;
        n = bd.size();
        // Reference: a burst that fits is replayed whole; a longer one keeps its
        // first DEPTH-1 beats followed by its true last beat.
        for (int i = 0; i < n; i++) begin
            if (n <= DEPTH || i < DEPTH - 1 || i == n - 1) begin
                exp_d.push_back(bd[i]);
                exp_r.push_back(br[i]);
            end
        end
        chk("s_rready_at_start", 64'(s_rready), 64'd1);
        for (int i = 0; i < n; i++) begin
            s_rvalid    = 1'b1;
            s_rid       = uid;
            s_rdata     = bd[i];
            s_rresp     = br[i];
            s_rlast     = (i == n - 1);
            restored_id = 4'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        chk("free_req_T1", 64'(free_req), 64'd1);
        chk("free_uid", 64'(free_unique_id), 64'(uid));
        chk("s_rready_in_free", 64'(s_rready), 64'd0);
        chk("busy_in_free", 64'(busy), 64'd1);
        restored_id = rid;
        @(negedge clk);
        restored_id = 4'($urandom);
        chk("free_req_one_cycle", 64'(free_req), 64'd0);
        chk("m_rvalid_T2", 64'(m_rvalid), 64'd0);
        free_ack = 1'b1;
        @(negedge clk);
        free_ack = 1'b0;
        chk("m_rvalid_T3", 64'(m_rvalid), 64'd1);
        done    = 1'b0;
        stalled = 1'b0;
        cyc     = 0;
        pd = '0; pr = '0; pid = '0; pl = 1'b0;
        while (!done && cyc < 300) begin
            case (rdy_mode)
                0:       m_rready = 1'b1;
                1:       m_rready = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
                default: m_rready = 1'($urandom_range(0, 1));
            endcase
            chk("s_rready_in_drain", 64'(s_rready), 64'd0);
            if (stalled) begin
                chk("stall_rvalid", 64'(m_rvalid), 64'd1);
                chk("stall_rdata", m_rdata, pd);
                chk("stall_rid", 64'(m_rid), 64'(pid));
                chk("stall_rresp", 64'(m_rresp), 64'(pr));
                chk("stall_rlast", 64'(m_rlast), 64'(pl));
            end
            if (m_rvalid && m_rready) begin
                got_d.push_back(m_rdata);
                got_r.push_back(m_rresp);
                got_l.push_back(m_rlast);
                got_id.push_back(m_rid);
                if (m_rlast) done = 1'b1;
            end
            stalled = m_rvalid && !m_rready;
            pd = m_rdata; pr = m_rresp; pid = m_rid; pl = m_rlast;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        m_rready = 1'b0;
        chk("drain_completed", 64'(done), 64'd1);
        chk("s_rready_after_drain", 64'(s_rready), 64'd1);
        chk("busy_after_drain", 64'(busy), 64'd0);
        chk("m_rvalid_after_drain", 64'(m_rvalid), 64'd0);
        chk("beat_count", 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            chk("beat_data", got_d[i], exp_d[i]);
            chk("beat_resp", 64'(got_r[i]), 64'(exp_r[i]));
            chk("beat_rid", 64'(got_id[i]), 64'(rid));
            chk("beat_last", 64'(got_l[i]), 64'(i == exp_d.size() - 1));
        end
        bd.delete();
        br.delete();
    endtask

    initial begin
        int snap;
        rst = 1'b1; s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0;
        s_rlast = 1'b0; restored_id = '0; free_ack = 1'b0; m_rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_free_req", 64'(free_req), 64'd0);
        chk("rst_free_uid", 64'(free_unique_id), 64'd0);
        chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
        chk("rst_m_rlast", 64'(m_rlast), 64'd0);
        chk("rst_m_rid", 64'(m_rid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_rready", 64'(s_rready), 64'd1);
`ifdef R_BURST_ID_RESTORER_ERR_CHECK_EN
        chk("rst_err", 64'(err), 64'd0);
`endif

        // 4-beat burst, UID 0x23 -> ID 0x5
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) begin
            bd.push_back(64'hA0 + 64'(i));
            br.push_back(2'b00);
        end
        run_burst(8'h23, 4'h5);
`ifdef R_BURST_ID_RESTORER_ERR_CHECK_EN
        chk("err_clean_burst", 64'(err), 64'd0);
`endif

        // Single-beat burst with SLVERR
        bd.push_back({$urandom, $urandom});
        br.push_back(2'b10);
        run_burst(8'h7C, 4'hA);

        // Upstream stall pattern during drain
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) begin
            bd.push_back({$urandom, $urandom});
            br.push_back(2'($urandom));
        end
        run_burst(8'h41, 4'h3);

        // 18-beat overflow burst
        rdy_mode = 0;
        for (int i = 0; i < 18; i++) begin
            bd.push_back(64'h1000 + 64'(i));
            br.push_back((i == 17) ? 2'b11 : 2'b00);
        end
        run_burst(8'h99, 4'hE);
`ifdef R_BURST_ID_RESTORER_ERR_CHECK_EN
        chk("err_overflow", 64'(err), 64'd1);
`endif

        // Reset in the middle of collection
        snap = free_cnt;
        for (int i = 0; i < 2; i++) begin
            s_rvalid = 1'b1; s_rid = 8'h55; s_rdata = 64'(i); s_rresp = 2'b00; s_rlast = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        s_rvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_s_rready", 64'(s_rready), 64'd1);
        chk("midrst_m_rvalid", 64'(m_rvalid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("midrst_no_free", 64'(free_cnt), 64'(snap));
`ifdef R_BURST_ID_RESTORER_ERR_CHECK_EN
        chk("midrst_err_cleared", 64'(err), 64'd0);
`endif
        bd.push_back(64'hDEAD_0001); br.push_back(2'b00);
        bd.push_back(64'hDEAD_0002); br.push_back(2'b01);
        run_burst(8'h56, 4'h9);

        // Back-to-back bursts: second starts right after the first drain handshake
        snap = free_cnt;
        for (int i = 0; i < 3; i++) begin
            bd.push_back({$urandom, $urandom});
            br.push_back(2'($urandom));
        end
        run_burst(8'h10, 4'h1);
        for (int i = 0; i < 2; i++) begin
            bd.push_back({$urandom, $urandom});
            br.push_back(2'($urandom));
        end
        run_burst(8'h11, 4'h2);
        chk("b2b_free_pulses", 64'(free_cnt - snap), 64'd2);

        // Randomized bursts, lengths straddling the buffer depth
        rdy_mode = 2;
        for (int k = 0; k < 20; k++) begin
            int n;
            n = $urandom_range(1, DEPTH + 4);
            for (int i = 0; i < n; i++) begin
                bd.push_back({$urandom, $urandom});
                br.push_back(2'($urandom));
            end
            run_burst(8'($urandom), 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
